// File: rtl/drac_icache_pkg.sv
// Shared instruction-cache geometry and index types used by the replacement logic.
package drac_icache_pkg;

    localparam int ICACHE_N_WAY = 4;
    localparam int ICACHE_N_SET = 64;
    localparam int ICACHE_WAY_W = $clog2(ICACHE_N_WAY);
    localparam int ICACHE_SET_W = $clog2(ICACHE_N_SET);

    typedef logic [ICACHE_WAY_W-1:0] way_idx_t;
    typedef logic [ICACHE_SET_W-1:0] set_idx_t;
    typedef logic [ICACHE_N_WAY-2:0] plru_t;

endpackage

// File: rtl/icache_ffs.sv
// Find-first-set: index of the lowest set bit of vec_i, empty_o when no bit is set.
module icache_ffs #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         empty_o
);

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        idx_o   = '0;
        empty_o = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = W'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_way_replace.sv
// Victim-way selection for the icache refill path: lowest invalid way first,
// otherwise the tree-PLRU victim of the addressed set.
module icache_way_replace
    import drac_icache_pkg::*;
#(
    parameter int N_WAY = ICACHE_N_WAY,
    parameter int N_SET = ICACHE_N_SET,
    localparam int SET_W = $clog2(N_SET),
    localparam int WAY_W = $clog2(N_WAY)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    input  logic [SET_W-1:0] req_set_i,
    input  logic [N_WAY-1:0] req_valid_ways_i,
    input  logic             upd_valid_i,
    input  logic [SET_W-1:0] upd_set_i,
    input  logic [WAY_W-1:0] upd_way_i,
    output logic             victim_valid_o,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             victim_inval_o,
    output logic             all_valid_o
);

    // Heap-ordered tree walk: a 0 bit descends left (lower ways), 1 descends right.
    function automatic logic [WAY_W-1:0] plru_walk(input logic [N_WAY-2:0] tree);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        logic             b;
        node = '0;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b    = tree[node];
            way  = WAY_W'({way, b});
            node = WAY_W'(32'(node) * 2 + 32'(b) + 1);
        end
        return way;
    endfunction

    // Every node on the path to the accessed way is turned to point away from it.
    function automatic logic [N_WAY-2:0] plru_update(input logic [N_WAY-2:0] tree,
                                                     input logic [WAY_W-1:0] way);
        logic [N_WAY-2:0] nxt;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] path;
        logic             b;
        nxt  = tree;
        node = '0;
        path = way;
        for (int l = 0; l < WAY_W; l++) begin
            b         = path[WAY_W-1];
            nxt[node] = ~b;
            node      = WAY_W'(32'(node) * 2 + 32'(b) + 1);
            path      = path << 1;
        end
        return nxt;
    endfunction

    logic [N_WAY-2:0] plru_q [N_SET];
    logic [WAY_W-1:0] ffs_idx;
    logic             ffs_empty;
    logic [WAY_W-1:0] pick_way;

    logic             vld_p1;
    logic [WAY_W-1:0] way_p1;
    logic             inval_p1;
    logic             all_valid_p1;

    icache_ffs #(.N(N_WAY)) u_ffs (
        .vec_i   (~req_valid_ways_i),
        .idx_o   (ffs_idx),
        .empty_o (ffs_empty)
    );

    always_comb begin
        pick_way = ffs_idx;
        if (ffs_empty) pick_way = plru_walk(plru_q[req_set_i]);
    end

    // Stage p0 -> p1: request result registered; reads the pre-update state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p1       <= 1'b0;
            way_p1       <= '0;
            inval_p1     <= 1'b0;
            all_valid_p1 <= 1'b0;
        end else begin
            vld_p1 <= req_valid_i;
            if (req_valid_i) begin
                way_p1       <= pick_way;
                inval_p1     <= ~ffs_empty;
                all_valid_p1 <= ffs_empty;
            end
        end
    end

    // PLRU state: flush wins over a same-cycle update.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < N_SET; s++) plru_q[s] <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < N_SET; s++) plru_q[s] <= '0;
        end else if (upd_valid_i) begin
            plru_q[upd_set_i] <= plru_update(plru_q[upd_set_i], upd_way_i);
        end
    end

    assign victim_valid_o = vld_p1;
    assign victim_way_o   = way_p1;
    assign victim_inval_o = inval_p1;
    assign all_valid_o    = all_valid_p1;

endmodule

// File: tb/tb_icache_way_replace.sv
// Directed bench for icache_way_replace: a 4-way and an 8-way instance side by side.
module tb_icache_way_replace;

    logic clk = 1'b0;
    logic rstn;

    logic       flush4, rv4, uv4;
    logic [5:0] rs4, us4;
    logic [3:0] rw4;
    logic [1:0] uw4;
    logic       vv4, vi4, av4;
    logic [1:0] vw4;

    logic       flush8, rv8, uv8;
    logic [5:0] rs8, us8;
    logic [7:0] rw8;
    logic [2:0] uw8;
    logic       vv8, vi8, av8;
    logic [2:0] vw8;

    logic [4:0] out4;
    logic [5:0] out8;
    assign out4 = {vv4, vw4, vi4, av4};
    assign out8 = {vv8, vw8, vi8, av8};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    icache_way_replace #(.N_WAY(4), .N_SET(64)) dut4 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush4),
        .req_valid_i(rv4), .req_set_i(rs4), .req_valid_ways_i(rw4),
        .upd_valid_i(uv4), .upd_set_i(us4), .upd_way_i(uw4),
        .victim_valid_o(vv4), .victim_way_o(vw4),
        .victim_inval_o(vi4), .all_valid_o(av4)
    );

    icache_way_replace #(.N_WAY(8), .N_SET(64)) dut8 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush8),
        .req_valid_i(rv8), .req_set_i(rs8), .req_valid_ways_i(rw8),
        .upd_valid_i(uv8), .upd_set_i(us8), .upd_way_i(uw8),
        .victim_valid_o(vv8), .victim_way_o(vw8),
        .victim_inval_o(vi8), .all_valid_o(av8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush4 = 1'b0; rv4 = 1'b0; uv4 = 1'b0;
        flush8 = 1'b0; rv8 = 1'b0; uv8 = 1'b0;
    endtask

    task automatic req4(input logic [5:0] s, input logic [3:0] w);
        rv4 = 1'b1; rs4 = s; rw4 = w;
    endtask

    task automatic upd4(input logic [5:0] s, input logic [1:0] w);
        uv4 = 1'b1; us4 = s; uw4 = w;
    endtask

    task automatic test_reset();
        vectors++;
        if (out4 !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_out4 got %b want %b", out4, 5'b0);
        end
        vectors++;
        if (out8 !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_out8 got %b want %b", out8, 6'b0);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_invalid_search();
        logic [3:0] pat [7];
        logic [1:0] exp [7];
        pat = '{4'b1011, 4'b0000, 4'b0111, 4'b1100, 4'b1010, 4'b1001, 4'b1101};
        exp = '{2'd2,    2'd0,    2'd3,    2'd0,    2'd0,    2'd1,    2'd1};
        for (int i = 0; i < 7; i++) begin
            req4(6'd5, pat[i]);
            tick();
            idle();
            vectors++;
            if (out4 !== {1'b1, exp[i], 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL invalid_search[%0d] got %b want %b", i, out4, {1'b1, exp[i], 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_plru_sequence();
        req4(6'd3, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL plru_first got %b want %b", out4, {1'b1, 2'd0, 1'b0, 1'b1});
        end
        upd4(6'd3, 2'd0); tick(); idle();
        vectors++;
        if (out4 !== {1'b0, 2'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL plru_hold got %b want %b", out4, {1'b0, 2'd0, 1'b0, 1'b1});
        end
        req4(6'd3, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL plru_after_w0 got %b want %b", out4, {1'b1, 2'd2, 1'b0, 1'b1});
        end
        upd4(6'd3, 2'd2); tick(); idle();
        req4(6'd3, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL plru_after_w2 got %b want %b", out4, {1'b1, 2'd1, 1'b0, 1'b1});
        end
        tick();
        vectors++;
        if (out4 !== {1'b0, 2'd1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL plru_idle_hold got %b want %b", out4, {1'b0, 2'd1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_same_cycle();
        upd4(6'd7, 2'd0);
        req4(6'd7, 4'hF);
        tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL same_cycle_old got %b want %b", out4, {1'b1, 2'd0, 1'b0, 1'b1});
        end
        req4(6'd7, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL same_cycle_new got %b want %b", out4, {1'b1, 2'd2, 1'b0, 1'b1});
        end
    endtask

    task automatic test_set_isolation();
        upd4(6'd1, 2'd0); tick(); idle();
        req4(6'd2, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL isolation_set2 got %b want %b", out4, {1'b1, 2'd0, 1'b0, 1'b1});
        end
        req4(6'd1, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL isolation_set1 got %b want %b", out4, {1'b1, 2'd2, 1'b0, 1'b1});
        end
    endtask

    task automatic test_flush();
        // set 3 currently selects way 1; the same-cycle request must still see that
        flush4 = 1'b1;
        req4(6'd3, 4'hF);
        tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_preflush got %b want %b", out4, {1'b1, 2'd1, 1'b0, 1'b1});
        end
        for (int s = 0; s < 64; s++) begin
            req4(6'(s), 4'hF);
            tick();
            vectors++;
            if (out4 !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL flush_set[%0d] got %b want %b", s, out4, {1'b1, 2'd0, 1'b0, 1'b1});
            end
        end
        idle();
        flush4 = 1'b1;
        upd4(6'd5, 2'd0);
        tick(); idle();
        req4(6'd5, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_beats_update got %b want %b", out4, {1'b1, 2'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_nway8();
        logic [2:0] ways [4];
        int seen;
        ways = '{3'd0, 3'd4, 3'd2, 3'd6};
        for (int i = 0; i < 4; i++) begin
            uv8 = 1'b1; us8 = 6'd9; uw8 = ways[i];
            tick(); idle();
        end
        rv8 = 1'b1; rs8 = 6'd9; rw8 = 8'hEF;
        tick(); idle();
        vectors++;
        if (out8 !== {1'b1, 3'd4, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL n8_invalid got %b want %b", out8, {1'b1, 3'd4, 1'b1, 1'b0});
        end
        rv8 = 1'b1; rs8 = 6'd9; rw8 = 8'hFF;
        tick(); idle();
        vectors++;
        if (out8 !== {1'b1, 3'd1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL n8_plru got %b want %b", out8, {1'b1, 3'd1, 1'b0, 1'b1});
        end
        seen = 0;
        rv8 = 1'b1; rs8 = 6'd9; rw8 = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (vv8 === 1'b1 && vw8 === 3'd1) seen++;
        end
        idle();
        vectors++;
        if (seen !== 16) begin
            miscompares++;
            $display("FAIL n8_back_to_back got %0d valid cycles want 16", seen);
        end
        tick();
        vectors++;
        if (vv8 !== 1'b0) begin
            miscompares++;
            $display("FAIL n8_drain got %b want %b", vv8, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        upd4(6'd4, 2'd0); tick(); idle();
        req4(6'd4, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_pre got %b want %b", out4, {1'b1, 2'd2, 1'b0, 1'b1});
        end
        #3 rstn = 1'b0;
        #1;
        vectors++;
        if (out4 !== 5'b0) begin
            miscompares++;
            $display("FAIL async_out4 got %b want %b", out4, 5'b0);
        end
        vectors++;
        if (out8 !== 6'b0) begin
            miscompares++;
            $display("FAIL async_out8 got %b want %b", out8, 6'b0);
        end
        tick();
        rstn = 1'b1;
        req4(6'd4, 4'hF); tick(); idle();
        vectors++;
        if (out4 !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_state_cleared got %b want %b", out4, {1'b1, 2'd0, 1'b0, 1'b1});
        end
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        rs4 = '0; rw4 = '0; us4 = '0; uw4 = '0;
        rs8 = '0; rw8 = '0; us8 = '0; uw8 = '0;
        tick();
        tick();
        test_reset();
        test_invalid_search();
        test_plru_sequence();
        test_same_cycle();
        test_set_isolation();
        test_flush();
        test_nway8();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_way_replace.md
# icache_way_replace

Victim-way selection unit for the set-associative instruction cache, generalised to any power-of-two way count. On every refill request it returns the lowest-indexed invalid way if one exists, otherwise the tree-PLRU victim for the addressed set. It keeps per-set PLRU state updated by hits and refills. It sits beside the icache tag array and feeds the refill controller, replacing the purely combinational first-invalid-way search.

## Interface
- N_WAY, 4, number of ways; power of two, 2..16
- N_SET, 64, number of sets; power of two
- SET_W, $clog2(N_SET), set index width (derived)
- WAY_W, $clog2(N_WAY), way index width (derived)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  clear all PLRU state (icache invalidate-all)
- req_valid_i  in  1  victim request this cycle
- req_set_i  in  SET_W  set index of request
- req_valid_ways_i  in  N_WAY  tag-valid bits of that set, bit i = way i
- upd_valid_i  in  1  access notification (hit or completed refill)
- upd_set_i  in  SET_W  set index accessed
- upd_way_i  in  WAY_W  way accessed
- victim_valid_o  out  1  victim_way_o is valid this cycle
- victim_way_o  out  WAY_W  selected way
- victim_inval_o  out  1  1 = victim was an invalid way, 0 = PLRU choice
- all_valid_o  out  1  registered: requested set had no invalid way

## Operation
- PLRU state: N_SET entries × (N_WAY-1) bits, heap-indexed tree; node n children 2n+1 (left, lower ways) and 2n+2 (right).
- Node bit 0 = victim lies in left subtree, 1 = right subtree.
- Victim walk: from node 0, descend left on 0, right on 1; leaf order gives way index.
- Selection priority: if req_valid_ways_i != all-ones → victim = index of lowest set bit of ~req_valid_ways_i, victim_inval_o=1; else PLRU walk, victim_inval_o=0.
- Update on upd_valid_i: each node on the path to upd_way_i is set to point away from it (accessed way in left subtree → bit 1, in right → bit 0). Nodes off the path are unchanged.
- No implicit update on victim selection; the refill controller issues upd_* for the refilled way.
- flush_i: all PLRU entries cleared to 0 on that edge; overrides any update in the same cycle.
- Request and update in the same cycle to the same set: request reads pre-update state; update still commits.
- req_valid_ways_i is sampled only when req_valid_i=1; otherwise don't-care.

## Timing
- Reset: all PLRU bits 0; victim_valid_o=0, victim_way_o=0, victim_inval_o=0, all_valid_o=0.
- Latency 1: request in cycle t → victim_* and all_valid_o registered, valid in t+1.
- Fully pipelined: one request per cycle accepted; victim_valid_o follows req_valid_i delayed by one cycle.
- Outputs other than victim_valid_o hold last value when no request.
- Update latency 1: state written at edge ending cycle t; a request in t+1 sees it.
- flush_i with req_valid_i in the same cycle: the request result uses pre-flush state; a request in t+1 sees cleared state.
- rstn_i asserted mid-operation: all state and outputs return to reset values immediately.

## Structure
- drac_icache_pkg: ICACHE_N_WAY, ICACHE_N_SET, way_idx_t, set_idx_t, plru_t (N_WAY-1 bits) typedefs.
- Sub-module icache_ffs: parametrised find-first-set (N bits → index + empty flag), purely combinational, used for the invalid-way search.
- PLRU walk and update-mask functions are local to icache_way_replace; the state array is flops (no SRAM).

## Test plan
- After reset, N_WAY=4: request set 5, valid=4'b1011 → next cycle victim_way_o=2, victim_inval_o=1, all_valid_o=0.
- Set 3 all valid, no prior updates: request → victim 0; update way 0, then request → victim 2; update way 2, then request → victim 1.
- Same-cycle update (set 7, way 0) and request (set 7, valid=4'hF) → victim 0 (old state); request next cycle → victim 2.
- Updates to set 1 leave set 2 untouched: after update (set 1, way 0), request set 2 all valid → victim 0.
- flush_i after several updates → every set returns victim 0 when all valid; flush with a simultaneous update → update discarded.
- N_WAY=8: updates to ways 0, 4, 2, 6 on one set, then request all valid → victim 1; back-to-back requests every cycle for 16 cycles → victim_valid_o high for 16 cycles.
